// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7 + x^6 + 1) checker: seeds its history from the
// received stream, locks after LOCK_CNT correct predictions, then counts bit errors.
module prbs7_checker #(
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I,
    input  logic             EN,
    input  logic             CLR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_COUNT
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_M = MISS_W'(LOSS_THRESH);

    typedef enum logic [1:0] {
        FILL,
        HUNT,
        LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         h_q, h_d;
    logic [2:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               err_d;

    logic               predict;
    logic               mismatch;
    logic [6:0]         h_shift;

    // Prediction uses the history before this sample is shifted in.
    assign predict  = h_q[5] ^ h_q[6];
    assign mismatch = I ^ predict;
    assign h_shift  = {h_q[5:0], I};

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_d   = ERR_COUNT;

        if (EN) begin
            h_d = h_shift;
            case (state_q)
                FILL: begin
                    if (fill_q == 3'd6) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end

                HUNT: begin
                    // An all-zero history is a valid LFSR fixed point, so it must never count.
                    if (mismatch || (h_shift == '0)) begin
                        match_d = '0;
                    end else if ((match_q + MATCH_W'(1)) == LOCK_M) begin
                        state_d = LOCK;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end

                LOCK: begin
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (ERR_COUNT != '1) begin
                            cnt_d = ERR_COUNT + CNT_W'(1);
                        end
                        if ((miss_q + MISS_W'(1)) == LOSS_M) begin
                            state_d = HUNT;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end

                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                    match_d = '0;
                    miss_d  = '0;
                end
            endcase
        end

        if (CLR) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= FILL;
            h_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            LOCKED    <= 1'b0;
            ERR       <= 1'b0;
            ERR_COUNT <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            LOCKED    <= (state_d == LOCK);
            ERR       <= err_d;
            ERR_COUNT <= cnt_d;
        end
    end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Self-synchronising checker for the PRBS7 stream produced by the 7-bit Fibonacci LFSR (x^7 + x^6 + 1, new bit = bit 5 XOR bit 6 of the shift register, newest bit in bit 0). It sits directly downstream of the LFSR, or at the far end of a link carrying its serial output bit. It locks onto the sequence without knowing the seed, then flags and counts bit errors. It is used for board and link bring-up on the ice40 targets.

## Interface

Parameters:
- LOCK_CNT, default 16: consecutive correct predictions required to declare lock.
- LOSS_THRESH, default 4: consecutive mispredictions while locked that drop lock.
- CNT_W, default 16: width of the error counter.

Ports:
- CLK  input  1  system clock, all state on the rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- I  input  1  received PRBS bit.
- EN  input  1  sample strobe. I is consumed only on edges where EN=1. Tie high when fed by a free-running LFSR.
- CLR  input  1  synchronous clear of ERR_COUNT.
- LOCKED  output  1  checker is locked to the sequence.
- ERR  output  1  one-cycle pulse on each counted error.
- ERR_COUNT  output  CNT_W  saturating count of errors seen while locked.

## Operation

- History register h[6:0] holds the received bits. h[0] is the newest. On each EN sample: h <= {h[5:0], I}.
- Prediction for the sample is p = h[5] ^ h[6], taken before the shift. A mismatch is I != p.
- Received bits always enter h; predicted bits never do. As a result, one corrupted input bit produces exactly 3 mismatches, at sample offsets 0, +6 and +7, provided no other corruption falls within 7 samples.
- State machine FILL -> HUNT -> LOCK:
  - FILL, entered at reset: the first 7 samples only load h. No comparisons, no errors. Go to HUNT after the 7th sample.
  - HUNT: on a match, match_cnt increments; on a mismatch, match_cnt is cleared.
    - When a match brings match_cnt to LOCK_CNT and the post-shift h != 0, go to LOCK.
    - If h == 0, match_cnt is held at 0, so an all-zero stream can never lock.
    - Errors are not counted in HUNT.
  - LOCK, on a mismatch: ERR pulses, ERR_COUNT increments, miss_cnt increments.
    - When miss_cnt reaches LOSS_THRESH, go to HUNT with match_cnt=0.
    - The mismatch that triggers loss is itself counted.
  - LOCK, on a match: miss_cnt is cleared.
  - Leaving LOCK keeps h intact. There is no refill.
- ERR_COUNT saturates at 2^CNT_W-1 and stops there; it never wraps.
- CLR=1 sets ERR_COUNT to 0 at the next edge, regardless of EN.
  - CLR together with a counted mismatch: ERR_COUNT becomes 0, and ERR still pulses.
  - CLR does not affect LOCKED, the state machine or h.
- EN=0: no state changes, and ERR=0 on that edge. CLR still acts.
- Stuck-at-1 input predicts 0 forever and never locks. Stuck-at-0 is blocked by the h != 0 rule.

## Timing

- All outputs are registered. None is combinational from I.
- Reset (RESETN low, asynchronous, with no clock edge needed):
  - LOCKED=0, ERR=0, ERR_COUNT=0.
  - State is FILL; h, match_cnt and miss_cnt are 0.
  - Release is sampled on the next rising CLK.
- Latency: a sample taken at edge k drives ERR, ERR_COUNT and LOCKED from edge k onward, i.e. visible in the following cycle.
- Minimum lock time is 7 + LOCK_CNT EN samples after reset. With the defaults, LOCKED rises at the 23rd sample.
- ERR is high for exactly one cycle per counted error. Back-to-back errors give ERR high on consecutive cycles.
- LOCKED falls at the same edge as the LOSS_THRESH-th consecutive error pulse.
- Gaps in EN stretch all timing in cycles but not in samples.

## Test plan

1. Reset, then 300 golden samples from LFSR state 7'b0000001 with EN=1 -> LOCKED rises after sample 23, ERR never pulses, ERR_COUNT=0.
2. After lock, flip one bit at sample n -> ERR pulses at samples n, n+6 and n+7; ERR_COUNT=3; LOCKED stays 1.
3. After lock, flip 4 consecutive bits n..n+3 ->
   - ERR_COUNT=4 and LOCKED falls after sample n+3.
   - HUNT then sees mismatches at n+6 and n+10, which are not counted.
   - LOCKED rises again after sample n+26; ERR_COUNT still 4.
4. Input stuck at 0 for 200 samples, then stuck at 1 for 200 samples -> LOCKED stays 0, ERR stays 0, ERR_COUNT=0.
5. Run with CNT_W=4 while locked, and corrupt every 8th bit for 10 events (30 errors) -> ERR_COUNT sticks at 15. Then assert CLR on the same edge as a mismatch -> ERR pulses and ERR_COUNT=0.
6. While locked, EN toggled 0/1 every cycle, then RESETN pulsed low between clock edges ->
   - During the EN toggling, lock holds and there are no spurious ERR pulses.
   - Outputs go to 0 immediately when RESETN goes low.
   - After RESETN is released, relock takes 23 samples.
